// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: measures sync periods, locks to the
// configured raster and regenerates coordinates, active flag and frame start.
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BACK      = 48,
    parameter int V_BACK      = 33,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_active,
    output logic        o_frame_start,
    output logic        o_locked,
    output logic        o_err,
    output logic [10:0] o_h_total,
    output logic [10:0] o_v_total
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        UNSYNC,
        MEASURE,
        LOCKED
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_prev_hs;
    logic          r_prev_vs;
    logic          r_vs_pend;
    logic          r_bad;
    logic [GW-1:0] r_good;
    logic [10:0]   r_h_cnt;
    logic [10:0]   r_v_cnt;

    logic          w_hs_rise;
    logic          w_vs_rise;
    logic          w_bound;
    logic          w_timeout;
    logic          w_line_bad;
    logic          w_frame_bad;
    logic [10:0]   w_h_len;
    logic [10:0]   w_v_len;
    logic [10:0]   w_h_nxt;
    logic [10:0]   w_v_nxt;
    logic          w_bad_nxt;
    logic [GW-1:0] w_good_nxt;
    logic [GW-1:0] w_good_inc;
    logic          w_err;
    logic          w_h_in;
    logic          w_v_in;
    logic          w_act;

    // Edges are only qualified on strobes, so inter-strobe glitches vanish.
    assign w_hs_rise   = i_pix_stb & i_hs & ~r_prev_hs;
    assign w_vs_rise   = i_pix_stb & i_vs & ~r_prev_vs;
    assign w_bound     = w_hs_rise & (r_vs_pend | w_vs_rise);
    assign w_h_len     = r_h_cnt + 11'd1;
    assign w_v_len     = r_v_cnt + 11'd1;
    assign w_line_bad  = w_hs_rise & (w_h_len != 11'(H_TOTAL));
    assign w_frame_bad = (w_v_len != 11'(V_TOTAL));
    assign w_timeout   = i_pix_stb & ~w_hs_rise & (r_h_cnt == CNT_MAX - 11'd1);
    assign w_good_inc  = r_good + GW'(1);

    always_comb begin
        w_h_nxt = r_h_cnt;
        w_v_nxt = r_v_cnt;
        if (i_pix_stb) begin
            if (w_hs_rise) begin
                w_h_nxt = 11'd0;
            end else if (r_h_cnt != CNT_MAX) begin
                w_h_nxt = w_h_len;
            end
        end
        if (w_bound) begin
            w_v_nxt = 11'd0;
        end else if (w_hs_rise && r_v_cnt != CNT_MAX) begin
            w_v_nxt = w_v_len;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_err       = 1'b0;
        if (w_timeout) begin
            w_state_nxt = UNSYNC;
            w_good_nxt  = '0;
            w_bad_nxt   = 1'b0;
            w_err       = 1'b1;
        end else begin
            unique case (r_state)
                UNSYNC: begin
                    if (w_bound) begin
                        w_state_nxt = MEASURE;
                        w_good_nxt  = '0;
                        w_bad_nxt   = 1'b0;
                    end
                end
                MEASURE: begin
                    if (w_line_bad) begin
                        w_bad_nxt = 1'b1;
                    end
                    if (w_bound) begin
                        if (!r_bad && !w_line_bad && !w_frame_bad) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc == GW'(LOCK_FRAMES)) begin
                                w_state_nxt = LOCKED;
                            end
                        end else begin
                            w_good_nxt = '0;
                            w_err      = 1'b1;
                        end
                        w_bad_nxt = 1'b0;
                    end
                end
                LOCKED: begin
                    if (w_line_bad || (w_bound && w_frame_bad)) begin
                        w_state_nxt = MEASURE;
                        w_good_nxt  = '0;
                        w_bad_nxt   = 1'b0;
                        w_err       = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = UNSYNC;
                    w_good_nxt  = '0;
                    w_bad_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign w_h_in = (w_h_nxt >= 11'(H_BACK))
                 && (w_h_nxt <= 11'(H_BACK + H_ACTIVE - 1));
    assign w_v_in = (w_v_nxt >= 11'(V_BACK))
                 && (w_v_nxt <= 11'(V_BACK + V_ACTIVE - 1));
    assign w_act  = w_h_in & w_v_in & (w_state_nxt != UNSYNC);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= UNSYNC;
            r_prev_hs     <= 1'b1;
            r_prev_vs     <= 1'b1;
            r_vs_pend     <= 1'b0;
            r_bad         <= 1'b0;
            r_good        <= '0;
            r_h_cnt       <= 11'd0;
            r_v_cnt       <= 11'd0;
            o_x           <= 10'd0;
            o_y           <= 9'd0;
            o_active      <= 1'b0;
            o_frame_start <= 1'b0;
            o_locked      <= 1'b0;
            o_err         <= 1'b0;
            o_h_total     <= 11'd0;
            o_v_total     <= 11'd0;
        end else begin
            // Pulses are per clock, not per strobe.
            o_err         <= w_err;
            o_frame_start <= w_bound;
            if (i_pix_stb) begin
                r_prev_hs <= i_hs;
                r_prev_vs <= i_vs;
                r_h_cnt   <= w_h_nxt;
                r_v_cnt   <= w_v_nxt;
                r_state   <= w_state_nxt;
                r_good    <= w_good_nxt;
                r_bad     <= w_bad_nxt;
                o_locked  <= (w_state_nxt == LOCKED);
                o_active  <= w_act;
                o_x       <= w_act ? 10'(w_h_nxt - 11'(H_BACK)) : 10'd0;
                o_y       <= w_act ? 9'(w_v_nxt - 11'(V_BACK)) : 9'd0;
                if (w_bound) begin
                    r_vs_pend <= 1'b0;
                end else if (w_vs_rise) begin
                    r_vs_pend <= 1'b1;
                end
                if (w_hs_rise) begin
                    o_h_total <= w_h_len;
                end
                if (w_bound) begin
                    o_v_total <= w_v_len;
                end
            end
        end
    end

endmodule
